uart_tx_fifo_feeder: RTL and testbench
======================================

Name: uart_tx_fifo_feeder

Overview:
Byte FIFO and load sequencer that sits directly upstream of one 8N1 UART transmitter channel in the multi-serial block. Host logic pushes bytes at full clock rate. The feeder buffers them and issues them one at a time over the transmitter's TX_DATA / TX_LOAD / LOAD_OK handshake. It reports fill level, full status and overflow so the host can pace writes.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
BYTE_W, 8, data width; must match the transmitter.
CNT_W, $clog2(DEPTH)+1, width of FILL; holds the values 0..DEPTH.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
WR_DATA  in  BYTE_W  byte to enqueue.
WR_EN  in  1  enqueue strobe; one byte per cycle while high.
FLUSH  in  1  discard all queued, not-yet-loaded bytes.
CLR_OVF  in  1  clear the OVERFLOW flag.
WR_FULL  out  1  high when FILL == DEPTH.
FILL  out  CNT_W  number of queued bytes, registered.
OVERFLOW  out  1  sticky; set when a write is dropped.
BUSY  out  1  high when FILL != 0 or the sequencer is not in IDLE.
TX_DATA  out  BYTE_W  byte presented to the transmitter.
TX_LOAD  out  1  load request to the transmitter.
LOAD_OK  in  1  transmitter ready; it is high only while the transmitter is idle.

Behaviour:
- Reset (rst high at an edge): read and write pointers = 0, FILL = 0, WR_FULL = 0, OVERFLOW = 0, TX_LOAD = 0, TX_DATA = 0, BUSY = 0, state = IDLE. Reset mid-handshake abandons the handshake; the transmitter finishes any frame it has already latched.
- Storage: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. FILL tracks occupancy.
- Write rule: WR_EN accepted only if FILL < DEPTH in the registered value before the edge. A pop in the same cycle does not free space for that write.
- Dropped write: WR_EN while full sets OVERFLOW; memory and pointers unchanged.
- Clearing OVERFLOW: CLR_OVF clears it. If CLR_OVF and a drop occur in the same cycle, set wins.
- FLUSH:
  - read pointer := write pointer; FILL := 0.
  - A WR_EN in the same cycle is discarded and does not set OVERFLOW.
  - FLUSH does not affect a byte already popped into TX_DATA; that handshake completes.
  - FLUSH in IDLE suppresses any load that would have been issued that cycle.
- Simultaneous push and pop, not full and no FLUSH: FILL unchanged, both pointers advance.
- Sequencer states:
  - IDLE: if FILL != 0, LOAD_OK == 1 and FLUSH == 0, then TX_DATA := mem[rd_ptr], pop (rd_ptr+1, FILL-1), TX_LOAD := 1, go to LOAD. Otherwise TX_LOAD = 0.
  - LOAD: hold TX_LOAD = 1 and TX_DATA stable until LOAD_OK is sampled 0. Then set TX_LOAD := 0 and go to WAIT_DONE. There is no timeout: if the transmitter is disabled, the request is held indefinitely.
  - WAIT_DONE: TX_LOAD = 0; stay until LOAD_OK is sampled 1, then go to IDLE.
- TX_DATA holds its last value after the handshake ends.
- Latency: a byte written at edge N into an empty FIFO, with LOAD_OK high, gives FILL = 1 after N and TX_LOAD = 1 after edge N+1.
- Per-byte overhead: the feeder needs 1 cycle in IDLE to reissue after LOAD_OK returns high.
- Byte order: strictly FIFO; no byte is duplicated or skipped across pointer wrap.
- LOAD_OK low at reset release: the sequencer stays in IDLE until LOAD_OK goes high.

Test Plan:
1. Reset, then write 0x55 once with LOAD_OK = 1 → FILL = 1 for one cycle, TX_LOAD rises after the next edge with TX_DATA = 0x55. The model drops LOAD_OK 1 cycle later → TX_LOAD falls within 1 cycle; BUSY clears once LOAD_OK returns and state is IDLE.
2. Hold LOAD_OK = 0 and write 17 bytes 0x00..0x10 with DEPTH = 16 → WR_FULL = 1 after the 16th write, byte 0x10 dropped, OVERFLOW = 1. Release the transmitter model → exactly 0x00..0x0F emitted in order.
3. Fill to 16 entries, then assert WR_EN while a pop occurs in the same cycle → write dropped, OVERFLOW set, FILL = 15.
4. Queue 5 bytes; assert FLUSH together with WR_EN while in LOAD holding byte 1 → byte 1 completes its handshake, bytes 2..5 and the concurrent write are lost, FILL = 0, OVERFLOW = 0.
5. Stream 40 bytes back-to-back against a transmitter model with CYC_PER_BIT = 4 → all 40 emitted in order across two pointer wraps; TX_LOAD never high in IDLE or WAIT_DONE.
6. Assert rst during WAIT_DONE with FILL = 3 → next cycle FILL = 0, TX_LOAD = 0, TX_DATA = 0, BUSY = 0, OVERFLOW = 0.

Source files
------------

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus load sequencer feeding one 8N1 UART transmitter over the
// TX_DATA / TX_LOAD / LOAD_OK handshake.
module uart_tx_fifo_feeder #(
    parameter int DEPTH  = 16,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] WR_DATA,
    input  logic              WR_EN,
    input  logic              FLUSH,
    input  logic              CLR_OVF,
    output logic              WR_FULL,
    output logic [CNT_W-1:0]  FILL,
    output logic              OVERFLOW,
    output logic              BUSY,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              TX_LOAD,
    input  logic              LOAD_OK
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fill;
    logic              r_ovf;
    logic [BYTE_W-1:0] r_tx_data;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    // Fullness uses the registered count only, so a same-cycle pop never frees room.
    assign w_full = (r_fill == CNT_W'(DEPTH));
    assign w_push = WR_EN && !w_full && !FLUSH;
    assign w_drop = WR_EN &&  w_full && !FLUSH;
    assign w_pop  = (r_state == S_IDLE) && (r_fill != '0) && LOAD_OK && !FLUSH;

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= WR_DATA;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (FLUSH) begin
            r_rd_ptr <= r_wr_ptr;
            r_fill   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_fill <= r_fill + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (CLR_OVF)
            r_ovf <= 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (rst)
            r_tx_data <= '0;
        else if (w_pop)
            r_tx_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge sys_clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // No timeout in LOAD: a disabled transmitter holds the request forever.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)    w_next = S_LOAD;
            S_LOAD:  if (!LOAD_OK) w_next = S_WAIT;
            S_WAIT:  if (LOAD_OK)  w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_comb begin
        TX_LOAD  = (r_state == S_LOAD);
        BUSY     = (r_fill != '0) || (r_state != S_IDLE);
        WR_FULL  = w_full;
        FILL     = r_fill;
        OVERFLOW = r_ovf;
        TX_DATA  = r_tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: a cycle table for the basic handshake
// plus hand sequences driven against a simple transmitter model.
module tb_uart_tx_fifo_feeder;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       sys_clk = 0;
    logic       rst = 1;
    logic [7:0] WR_DATA = 0;
    logic       WR_EN = 0;
    logic       FLUSH = 0;
    logic       CLR_OVF = 0;
    logic       WR_FULL;
    logic [4:0] FILL;
    logic       OVERFLOW;
    logic       BUSY;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic       LOAD_OK;

    logic       tx_en = 0;
    logic       man_ok = 0;
    logic       m_ok = 1;
    int         m_cnt = 0;
    int         viol = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    assign LOAD_OK = tx_en ? m_ok : man_ok;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .BYTE_W(8)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .WR_DATA (WR_DATA),
        .WR_EN   (WR_EN),
        .FLUSH   (FLUSH),
        .CLR_OVF (CLR_OVF),
        .WR_FULL (WR_FULL),
        .FILL    (FILL),
        .OVERFLOW(OVERFLOW),
        .BUSY    (BUSY),
        .TX_DATA (TX_DATA),
        .TX_LOAD (TX_LOAD),
        .LOAD_OK (LOAD_OK)
    );

    always #5 sys_clk = ~sys_clk;

    // Transmitter model: latches a byte when idle and TX_LOAD is high, then is busy one frame.
    always @(posedge sys_clk) begin
        if (!tx_en) begin
            m_ok  <= 1'b1;
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            if (m_cnt < FRAME && TX_LOAD)
                viol <= viol + 1;
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1)
                m_ok <= 1'b1;
        end else if (TX_LOAD && m_ok) begin
            rx_q.push_back(TX_DATA);
            m_cnt <= FRAME;
            m_ok  <= 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tx_en = 0; man_ok = 0; WR_EN = 0; FLUSH = 0; CLR_OVF = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic       rst, wr, fl, clr, ok;
        logic [7:0] wd;
        logic [4:0] e_fill;
        logic       e_full, e_ovf, e_busy, e_load;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[16];

    initial begin
        //          rst wr  fl  clr ok  wd     fill full ovf busy load data
        vt[0]  = '{1, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        vt[1]  = '{0, 1, 0, 0, 1, 8'h55, 1, 0, 0, 1, 0, 8'h00};
        vt[2]  = '{0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 1, 8'h55};
        vt[3]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h55};
        vt[4]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h55};
        vt[5]  = '{0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h55};
        vt[6]  = '{0, 1, 0, 0, 0, 8'hAA, 1, 0, 0, 1, 0, 8'h55};
        vt[7]  = '{0, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h55};
        vt[8]  = '{0, 1, 0, 0, 1, 8'hBB, 1, 0, 0, 1, 0, 8'h55};
        vt[9]  = '{0, 1, 0, 0, 1, 8'hCC, 1, 0, 0, 1, 1, 8'hBB};
        vt[10] = '{0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 1, 8'hBB};
        vt[11] = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'hBB};
        vt[12] = '{0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 8'hBB};
        vt[13] = '{0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 1, 8'hCC};
        vt[14] = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hCC};
        vt[15] = '{0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'hCC};

        tick();
        for (int i = 0; i < 16; i++) begin
            rst = vt[i].rst; WR_EN = vt[i].wr; WR_DATA = vt[i].wd;
            FLUSH = vt[i].fl; CLR_OVF = vt[i].clr; man_ok = vt[i].ok;
            tick();
            chk($sformatf("vec%0d fill", i), 32'(FILL), 32'(vt[i].e_fill));
            chk($sformatf("vec%0d full", i), 32'(WR_FULL), 32'(vt[i].e_full));
            chk($sformatf("vec%0d ovf", i), 32'(OVERFLOW), 32'(vt[i].e_ovf));
            chk($sformatf("vec%0d busy", i), 32'(BUSY), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d load", i), 32'(TX_LOAD), 32'(vt[i].e_load));
            chk($sformatf("vec%0d data", i), 32'(TX_DATA), 32'(vt[i].e_data));
        end
        rst = 0; WR_EN = 0; FLUSH = 0; CLR_OVF = 0;

        // Overflow with stalled transmitter, then drain in order.
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            WR_EN = 1; WR_DATA = 8'(i);
            tick();
            if (i == 15) begin
                chk("ovf16 full", 32'(WR_FULL), 1);
                chk("ovf16 fill", 32'(FILL), 16);
                chk("ovf16 ovf", 32'(OVERFLOW), 0);
            end
        end
        WR_EN = 0;
        chk("ovf17 ovf", 32'(OVERFLOW), 1);
        chk("ovf17 fill", 32'(FILL), 16);
        rx_q.delete();
        tx_en = 1;
        for (int c = 0; c < 3000 && rx_q.size() < 16; c++) tick();
        for (int c = 0; c < 60; c++) tick();
        chk("ovf drain count", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("ovf byte%0d", i), 32'(rx_q[i]), 32'(i));
        chk("ovf drain busy", 32'(BUSY), 0);
        chk("ovf sticky", 32'(OVERFLOW), 1);
        CLR_OVF = 1; tick(); CLR_OVF = 0;
        chk("ovf cleared", 32'(OVERFLOW), 0);

        // Full FIFO: write coincident with pop is dropped; drop beats CLR_OVF.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            WR_EN = 1; WR_DATA = 8'hA0 + 8'(i);
            tick();
        end
        man_ok = 1; WR_EN = 1; WR_DATA = 8'hEE; CLR_OVF = 1;
        tick();
        chk("popdrop fill", 32'(FILL), 15);
        chk("popdrop ovf", 32'(OVERFLOW), 1);
        chk("popdrop load", 32'(TX_LOAD), 1);
        chk("popdrop data", 32'(TX_DATA), 32'hA0);
        man_ok = 0; WR_EN = 0; CLR_OVF = 0;
        tick();
        chk("popdrop wait load", 32'(TX_LOAD), 0);
        chk("popdrop ovf hold", 32'(OVERFLOW), 1);

        // FLUSH while LOAD holds the first byte.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            WR_EN = 1; WR_DATA = 8'(i);
            tick();
        end
        WR_EN = 0; man_ok = 1;
        tick();
        chk("flush pop fill", 32'(FILL), 4);
        chk("flush pop load", 32'(TX_LOAD), 1);
        FLUSH = 1; WR_EN = 1; WR_DATA = 8'h99;
        tick();
        FLUSH = 0; WR_EN = 0;
        chk("flush fill", 32'(FILL), 0);
        chk("flush ovf", 32'(OVERFLOW), 0);
        chk("flush load held", 32'(TX_LOAD), 1);
        chk("flush data held", 32'(TX_DATA), 1);
        man_ok = 0;
        tick();
        chk("flush load drop", 32'(TX_LOAD), 0);
        man_ok = 1;
        tick();
        tick();
        chk("flush idle busy", 32'(BUSY), 0);
        chk("flush no reload", 32'(TX_LOAD), 0);
        chk("flush data last", 32'(TX_DATA), 1);

        // Stream 40 bytes through the model, pacing on WR_FULL.
        do_reset();
        rx_q.delete(); exp_q.delete();
        viol = 0;
        tx_en = 1;
        begin
            int sent = 0;
            for (int c = 0; c < 3000 && sent < 40; c++) begin
                if (!WR_FULL) begin
                    WR_EN = 1; WR_DATA = 8'(sent * 37 + 5);
                    exp_q.push_back(WR_DATA);
                    sent++;
                end else begin
                    WR_EN = 0;
                end
                tick();
            end
            WR_EN = 0;
            chk("stream sent", sent, 40);
        end
        for (int c = 0; c < 4000 && rx_q.size() < 40; c++) tick();
        for (int c = 0; c < 60; c++) tick();
        chk("stream count", rx_q.size(), 40);
        for (int i = 0; i < 40 && i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("stream byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk("stream load outside LOAD", viol, 0);
        chk("stream ovf", 32'(OVERFLOW), 0);
        chk("stream busy", 32'(BUSY), 0);

        // Reset during WAIT_DONE with 3 bytes queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1; WR_DATA = 8'h11 + 8'(i);
            tick();
        end
        WR_EN = 0; man_ok = 1;
        tick();
        chk("rst pop data", 32'(TX_DATA), 32'h11);
        man_ok = 0;
        tick();
        tick();
        chk("rst pre fill", 32'(FILL), 3);
        chk("rst pre load", 32'(TX_LOAD), 0);
        rst = 1;
        tick();
        rst = 0;
        chk("rst fill", 32'(FILL), 0);
        chk("rst load", 32'(TX_LOAD), 0);
        chk("rst data", 32'(TX_DATA), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst ovf", 32'(OVERFLOW), 0);
        chk("rst full", 32'(WR_FULL), 0);
        man_ok = 1;
        tick();
        chk("rst no load", 32'(TX_LOAD), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
